// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative restoring divider: default operand width and FSM states.
package div_iter_pkg;

   localparam int unsigned DivWidth = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_bit_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {2'b00, divisor_i};
      // Top bit of the difference is the borrow out of the trial subtraction.
      q_bit_o = ~diff[WIDTH+1];
      rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider behind an AXI-stream style handshake.
// One quotient bit per cycle; result packed as {quotient, remainder} with a one-cycle valid pulse.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int unsigned WIDTH  = DivWidth,
   parameter bit          SIGNED = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   output logic               m_axis_dout_tvalid
);

   localparam int unsigned CntW = $clog2(WIDTH);
   typedef logic [CntW-1:0] cnt_t;
   localparam cnt_t CntLast = cnt_t'(WIDTH - 1);

   div_state_e         state_q, state_d;
   cnt_t               cnt_q, cnt_d;
   logic [WIDTH:0]     rem_q, rem_d;
   // Holds the dividend bits still to be consumed (MSB side) and the quotient built so far (LSB side).
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic [2*WIDTH-1:0] dout_q, dout_d;
   logic               valid_q, valid_d;

   logic               accept;
   logic [WIDTH:0]     step_rem;
   logic               step_q;
   logic [WIDTH-1:0]   quo_next;
   logic [WIDTH-1:0]   q_fin;
   logic [WIDTH-1:0]   r_fin;

   assign accept                 = (state_q == StIdle) & s_axis_dividend_tvalid
                                   & s_axis_divisor_tvalid;
   assign s_axis_dividend_tready = accept;
   assign s_axis_divisor_tready  = accept;
   assign m_axis_dout_tdata      = dout_q;
   assign m_axis_dout_tvalid     = valid_q;

   div_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem_i     (rem_q),
      .bit_i     (quo_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_q)
   );

   assign quo_next = {quo_q[WIDTH-2:0], step_q};
   assign q_fin    = q_neg_q ? -quo_next : quo_next;
   assign r_fin    = r_neg_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      dout_d  = dout_q;
      valid_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StRun;
               cnt_d   = '0;
               rem_d   = '0;
               if (SIGNED) begin
                  // Negating the most negative value yields its own unsigned magnitude.
                  quo_d   = s_axis_dividend_tdata[WIDTH-1] ? -s_axis_dividend_tdata
                                                           : s_axis_dividend_tdata;
                  dvs_d   = s_axis_divisor_tdata[WIDTH-1] ? -s_axis_divisor_tdata
                                                          : s_axis_divisor_tdata;
                  q_neg_d = s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1];
                  r_neg_d = s_axis_dividend_tdata[WIDTH-1];
               end else begin
                  quo_d   = s_axis_dividend_tdata;
                  dvs_d   = s_axis_divisor_tdata;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
               end
            end
         end
         StRun: begin
            rem_d = step_rem;
            quo_d = quo_next;
            cnt_d = cnt_q + cnt_t'(1);
            if (cnt_q == CntLast) begin
               // Result is registered on entry to DONE so the pulse and data come from flops.
               state_d = StDone;
               dout_d  = {q_fin, r_fin};
               valid_d = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: an unsigned and a signed instance driven in lockstep, results checked
// against arithmetic reference models.
module tb_div_iter;

   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   dvd, dvs;
   logic           dvd_v, dvs_v;
   logic           u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy;
   logic [2*W-1:0] u_tdata, s_tdata;
   logic           u_tv, s_tv;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div_iter #(
      .WIDTH  (W),
      .SIGNED (1'b0)
   ) u_div_u (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_dividend_tdata  (dvd),
      .s_axis_dividend_tvalid (dvd_v),
      .s_axis_dividend_tready (u_dvd_rdy),
      .s_axis_divisor_tdata   (dvs),
      .s_axis_divisor_tvalid  (dvs_v),
      .s_axis_divisor_tready  (u_dvs_rdy),
      .m_axis_dout_tdata      (u_tdata),
      .m_axis_dout_tvalid     (u_tv)
   );

   div_iter #(
      .WIDTH  (W),
      .SIGNED (1'b1)
   ) u_div_s (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_dividend_tdata  (dvd),
      .s_axis_dividend_tvalid (dvd_v),
      .s_axis_dividend_tready (s_dvd_rdy),
      .s_axis_divisor_tdata   (dvs),
      .s_axis_divisor_tvalid  (dvs_v),
      .s_axis_divisor_tready  (s_dvs_rdy),
      .m_axis_dout_tdata      (s_tdata),
      .m_axis_dout_tvalid     (s_tv)
   );

   function automatic logic [2*W-1:0] ref_u(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) return {{W{1'b1}}, a};
      return {a / b, a % b};
   endfunction

   function automatic logic [2*W-1:0] ref_s(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         q = (sa >= 0) ? -1 : 1;
         r = sa;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
      return {q[W-1:0], r[W-1:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dvd_v = 1'b0;
      dvs_v = 1'b0;
   endtask

   // Called one cycle after the accept; returns the cycle offset of the pulse or -1.
   task automatic wait_pulse(output int lat, output logic [2*W-1:0] ru,
                             output logic [2*W-1:0] rs, output logic sv);
      lat = -1;
      ru  = '0;
      rs  = '0;
      sv  = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (u_tv === 1'b1) begin
            lat = k;
            ru  = u_tdata;
            rs  = s_tdata;
            sv  = s_tv;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      dvd   = '0;
      dvs   = '0;
      idle_inputs();
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({u_tv, s_tv} !== 2'b00) begin
         errors++;
         $display("FAIL reset_tvalid: got %b want 00", {u_tv, s_tv});
      end
      checks++;
      if (u_tdata !== '0) begin
         errors++;
         $display("FAIL reset_tdata_u: got %h want 0", u_tdata);
      end
      checks++;
      if (s_tdata !== '0) begin
         errors++;
         $display("FAIL reset_tdata_s: got %h want 0", s_tdata);
      end
      tick();
      reset = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if ({u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy} !== 4'h0) begin
         errors++;
         $display("FAIL idle_no_valid_tready: got %b want 0000",
                  {u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy});
      end
      tick();
   endtask

   task automatic test_unsigned_basic();
      int             pulses_u = 0;
      int             pulses_s = 0;
      int             at = -1;
      int             rdy_seen = 0;
      logic [2*W-1:0] du = '0;
      logic [2*W-1:0] ds = '0;
      dvd   = 32'd100;
      dvs   = 32'd7;
      dvd_v = 1'b1;
      dvs_v = 1'b1;
      @(negedge clk);
      checks++;
      if ({u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy} !== 4'hF) begin
         errors++;
         $display("FAIL basic_accept_tready: got %b want 1111",
                  {u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy});
      end
      tick();
      idle_inputs();
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (u_dvd_rdy | u_dvs_rdy | s_dvd_rdy | s_dvs_rdy) rdy_seen++;
         if (u_tv === 1'b1) begin
            pulses_u++;
            at = k;
            du = u_tdata;
         end
         if (s_tv === 1'b1) begin
            pulses_s++;
            ds = s_tdata;
         end
         tick();
      end
      checks++;
      if (rdy_seen !== 0) begin
         errors++;
         $display("FAIL basic_tready_after_accept: got %0d cycles want 0", rdy_seen);
      end
      checks++;
      if (pulses_u !== 1 || pulses_s !== 1 || at !== 33) begin
         errors++;
         $display("FAIL basic_pulse: got u=%0d s=%0d at %0d want 1 1 at 33",
                  pulses_u, pulses_s, at);
      end
      checks++;
      if (du !== 64'h0000000E_00000002) begin
         errors++;
         $display("FAIL basic_data_u: got %h want 0000000e00000002", du);
      end
      checks++;
      if (ds !== 64'h0000000E_00000002) begin
         errors++;
         $display("FAIL basic_data_s: got %h want 0000000e00000002", ds);
      end
   endtask

   task automatic test_signed_rules();
      logic [W-1:0]   ta [5];
      logic [W-1:0]   tb [5];
      logic [2*W-1:0] eu [5];
      logic [2*W-1:0] es [5];
      int             lat;
      logic [2*W-1:0] ru, rs;
      logic           sv;
      ta[0] = 32'hFFFFFFF9; tb[0] = 32'h00000002;
      ta[1] = 32'h00000007; tb[1] = 32'hFFFFFFFE;
      ta[2] = 32'h80000000; tb[2] = 32'hFFFFFFFF;
      ta[3] = 32'h00000005; tb[3] = 32'h00000000;
      ta[4] = 32'hFFFFFFFB; tb[4] = 32'h00000000;
      es[0] = 64'hFFFFFFFD_FFFFFFFF;
      es[1] = 64'hFFFFFFFD_00000001;
      es[2] = 64'h80000000_00000000;
      es[3] = 64'hFFFFFFFF_00000005;
      es[4] = 64'h00000001_FFFFFFFB;
      eu[0] = ref_u(ta[0], tb[0]);
      eu[1] = ref_u(ta[1], tb[1]);
      eu[2] = 64'h00000000_80000000;
      eu[3] = 64'hFFFFFFFF_00000005;
      eu[4] = 64'hFFFFFFFF_FFFFFFFB;
      for (int i = 0; i < 5; i++) begin
         dvd   = ta[i];
         dvs   = tb[i];
         dvd_v = 1'b1;
         dvs_v = 1'b1;
         tick();
         idle_inputs();
         wait_pulse(lat, ru, rs, sv);
         checks++;
         if (lat !== 33 || sv !== 1'b1) begin
            errors++;
            $display("FAIL sign_case%0d_latency: got %0d (s pulse %b) want 33 (1)", i, lat, sv);
         end
         checks++;
         if (rs !== es[i]) begin
            errors++;
            $display("FAIL sign_case%0d_signed: got %h want %h", i, rs, es[i]);
         end
         checks++;
         if (ru !== eu[i]) begin
            errors++;
            $display("FAIL sign_case%0d_unsigned: got %h want %h", i, ru, eu[i]);
         end
         tick();
      end
   endtask

   task automatic test_handshake();
      int             lat;
      logic [2*W-1:0] ru, rs;
      logic           sv;
      int             first_acc = -1;
      int             np = 0;
      int             pc [2];
      logic [2*W-1:0] pu [2];
      logic [2*W-1:0] ps [2];
      int             lone_rdy = 0;
      // Lone dividend must wait for the divisor.
      dvd   = 32'd20;
      dvs   = 32'd6;
      dvd_v = 1'b1;
      dvs_v = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (u_dvd_rdy | u_dvs_rdy | s_dvd_rdy | s_dvs_rdy) lone_rdy++;
         tick();
      end
      checks++;
      if (lone_rdy !== 0) begin
         errors++;
         $display("FAIL lone_valid_tready: got %0d ready cycles want 0", lone_rdy);
      end
      dvs_v = 1'b1;
      @(negedge clk);
      checks++;
      if ({u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy} !== 4'hF) begin
         errors++;
         $display("FAIL joined_valid_tready: got %b want 1111",
                  {u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy});
      end
      tick();
      idle_inputs();
      wait_pulse(lat, ru, rs, sv);
      checks++;
      if (lat !== 33 || ru !== ref_u(32'd20, 32'd6) || rs !== ref_s(32'd20, 32'd6)) begin
         errors++;
         $display("FAIL joined_result: got lat %0d u %h s %h want 33 %h %h", lat, ru, rs,
                  ref_u(32'd20, 32'd6), ref_s(32'd20, 32'd6));
      end
      tick();
      // New operands offered while busy wait until the divider is idle again.
      pc[0] = -1; pc[1] = -1;
      pu[0] = '0; pu[1] = '0;
      ps[0] = '0; ps[1] = '0;
      dvd   = 32'd1000;
      dvs   = 32'd33;
      dvd_v = 1'b1;
      dvs_v = 1'b1;
      for (int c = 0; c <= 80; c++) begin
         if (c == 1) idle_inputs();
         if (c == 10) begin
            dvd   = 32'hDEADBEEF;
            dvs   = 32'hFFFF1234;
            dvd_v = 1'b1;
            dvs_v = 1'b1;
         end
         if (first_acc > 0 && c == first_acc + 1) idle_inputs();
         @(negedge clk);
         if (c >= 1 && first_acc < 0 && (u_dvd_rdy | u_dvs_rdy)) first_acc = c;
         if (u_tv === 1'b1 && np < 2) begin
            pc[np] = c;
            pu[np] = u_tdata;
            ps[np] = s_tdata;
            np++;
         end
         tick();
      end
      checks++;
      if (first_acc !== 34) begin
         errors++;
         $display("FAIL busy_accept_cycle: got %0d want 34", first_acc);
      end
      checks++;
      if (np !== 2 || pc[0] !== 33 || pc[1] !== 67) begin
         errors++;
         $display("FAIL busy_pulses: got %0d pulses at %0d %0d want 2 at 33 67", np, pc[0], pc[1]);
      end
      checks++;
      if (pu[0] !== ref_u(32'd1000, 32'd33)) begin
         errors++;
         $display("FAIL busy_first_u: got %h want %h", pu[0], ref_u(32'd1000, 32'd33));
      end
      checks++;
      if (pu[1] !== ref_u(32'hDEADBEEF, 32'hFFFF1234)
          || ps[1] !== ref_s(32'hDEADBEEF, 32'hFFFF1234)) begin
         errors++;
         $display("FAIL busy_second: got u %h s %h want %h %h", pu[1], ps[1],
                  ref_u(32'hDEADBEEF, 32'hFFFF1234), ref_s(32'hDEADBEEF, 32'hFFFF1234));
      end
   endtask

   task automatic test_reset_mid();
      int             pulses = 0;
      int             lat;
      logic [2*W-1:0] ru, rs;
      logic           sv;
      dvd   = 32'd12345;
      dvs   = 32'd7;
      dvd_v = 1'b1;
      dvs_v = 1'b1;
      for (int c = 0; c <= 50; c++) begin
         if (c == 1) idle_inputs();
         if (c == 15) reset = 1'b1;
         if (c == 16) reset = 1'b0;
         @(negedge clk);
         if (u_tv === 1'b1 || s_tv === 1'b1) pulses++;
         if (c < 50) tick();
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL reset_mid_pulse: got %0d pulses want 0", pulses);
      end
      checks++;
      if (u_tdata !== '0 || s_tdata !== '0) begin
         errors++;
         $display("FAIL reset_mid_tdata: got u %h s %h want 0", u_tdata, s_tdata);
      end
      tick();
      dvd   = 32'd9;
      dvs   = 32'd3;
      dvd_v = 1'b1;
      dvs_v = 1'b1;
      tick();
      idle_inputs();
      wait_pulse(lat, ru, rs, sv);
      checks++;
      if (lat !== 33 || ru !== 64'h00000003_00000000 || rs !== 64'h00000003_00000000) begin
         errors++;
         $display("FAIL reset_mid_fresh: got lat %0d u %h s %h want 33 {3,0}", lat, ru, rs);
      end
      tick();
   endtask

   task automatic new_operands();
      dvd = $urandom;
      dvs = $urandom;
      case ($urandom_range(0, 7))
         0: dvs = $urandom_range(0, 3);
         1: dvs = -$urandom_range(1, 9);
         2: dvd = 32'h80000000;
         3: dvs = $urandom_range(1, 255);
         4: dvd = $urandom_range(0, 1000);
         default: ;
      endcase
   endtask

   task automatic test_back_to_back();
      logic [2*W-1:0] qu [$];
      logic [2*W-1:0] qs [$];
      logic [2*W-1:0] eu, es;
      int             issued = 0;
      int             got = 0;
      int             last_pulse = -1;
      logic           acc;
      new_operands();
      dvd_v = 1'b1;
      dvs_v = 1'b1;
      for (int c = 0; c < 1000 * 34 + 200 && got < 1000; c++) begin
         @(negedge clk);
         acc = u_dvd_rdy & u_dvs_rdy;
         if (acc) begin
            qu.push_back(ref_u(dvd, dvs));
            qs.push_back(ref_s(dvd, dvs));
            issued++;
         end
         if (u_tv === 1'b1) begin
            eu = (qu.size() > 0) ? qu.pop_front() : 'x;
            es = (qs.size() > 0) ? qs.pop_front() : 'x;
            checks++;
            if (u_tdata !== eu) begin
               errors++;
               $display("FAIL b2b_u op%0d: got %h want %h", got, u_tdata, eu);
            end
            checks++;
            if (s_tv !== 1'b1 || s_tdata !== es) begin
               errors++;
               $display("FAIL b2b_s op%0d: got valid %b data %h want 1 %h", got, s_tv, s_tdata, es);
            end
            if (last_pulse >= 0) begin
               checks++;
               if (c - last_pulse !== 34) begin
                  errors++;
                  $display("FAIL b2b_spacing op%0d: got %0d want 34", got, c - last_pulse);
               end
            end
            last_pulse = c;
            got++;
         end
         tick();
         if (acc) begin
            if (issued < 1000) new_operands();
            else idle_inputs();
         end
      end
      idle_inputs();
      checks++;
      if (got !== 1000 || issued !== 1000) begin
         errors++;
         $display("FAIL b2b_count: got %0d results %0d issued want 1000 1000", got, issued);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed_rules();
      test_handshake();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
